// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with dead time, PWM dimming,
// leading-zero suppression, hex decode and frame-synchronous data update.
module sevenseg_scan_ctrl #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 25000,
  parameter int DEAD           = 1,
  parameter int BRIGHT_W       = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input  logic                       FPGA_CLK,
  input  logic                       FPGA_RST_N,
  input  logic [4*DIGITS-1:0]        data,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic [DIGITS-1:0]          blank,
  input  logic                       load,
  input  logic                       lz_blank,
  input  logic [BRIGHT_W-1:0]        bright,
  output logic [6:0]                 seg,
  output logic                       dt,
  output logic [DIGITS-1:0]          en_seg,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                ft_q, ft_d;

  logic [4*DIGITS-1:0] stg_data_q, stg_data_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0]   stg_blk_q, stg_blk_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]   shd_blk_q, shd_blk_d;

  logic [6:0]          seg_q, seg_d;
  logic                dt_q, dt_d;
  logic [DIGITS-1:0]   en_q, en_d;

  logic                slot_end, frame_end;
  logic [3:0]          nib;
  logic                dp_cur, blk_cur, zero_hi, sup, lit;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   en_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (cnt_q == CW'(CLK_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    ft_d      = frame_end;
    pwm_d     = pwm_q + 1'b1;

    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    stg_blk_d  = stg_blk_q;
    if (load) begin
      stg_data_d = data;
      stg_dp_d   = dp_in;
      stg_blk_d  = blank;
    end

    // a load coinciding with the boundary bypasses staging
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    shd_blk_d  = shd_blk_q;
    if (frame_end) begin
      shd_data_d = load ? data  : stg_data_q;
      shd_dp_d   = load ? dp_in : stg_dp_q;
      shd_blk_d  = load ? blank : stg_blk_q;
    end
  end

  always_comb begin
    nib     = '0;
    dp_cur  = 1'b0;
    blk_cur = 1'b0;
    zero_hi = 1'b1;
    sup     = 1'b0;
    // zero_hi covers nibbles i..DIGITS-1 when digit i is selected
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (shd_data_q[4*i +: 4] != 4'h0) zero_hi = 1'b0;
      if (idx_q == IW'(i)) begin
        nib     = shd_data_q[4*i +: 4];
        dp_cur  = shd_dp_q[i];
        blk_cur = shd_blk_q[i];
        sup     = lz_blank && zero_hi && (i != 0);
      end
    end

    seg_raw = hex7(nib);
    if (blk_cur || sup) seg_raw = '0;
    lit    = (cnt_q >= CW'(DEAD)) && (pwm_q <= bright) && !blk_cur;
    en_raw = lit ? (DIGITS'(1) << idx_q) : '0;

    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dt_d  = SEG_ACTIVE_LOW ^ (dp_cur & ~blk_cur);
    en_d  = EN_ACTIVE_LOW ? ~en_raw : en_raw;
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      cnt_q      <= '0;
      pwm_q      <= '0;
      idx_q      <= '0;
      ft_q       <= 1'b0;
      stg_data_q <= '0;
      stg_dp_q   <= '0;
      stg_blk_q  <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      shd_blk_q  <= '0;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dt_q       <= SEG_ACTIVE_LOW;
      en_q       <= {DIGITS{EN_ACTIVE_LOW}};
    end else begin
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      idx_q      <= idx_d;
      ft_q       <= ft_d;
      stg_data_q <= stg_data_d;
      stg_dp_q   <= stg_dp_d;
      stg_blk_q  <= stg_blk_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      shd_blk_q  <= shd_blk_d;
      seg_q      <= seg_d;
      dt_q       <= dt_d;
      en_q       <= en_d;
    end
  end

  assign seg        = seg_q;
  assign dt         = dt_q;
  assign en_seg     = en_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against an arithmetic model of the scan.
module tb_sevenseg_scan_ctrl;

  localparam int DIG  = 4;
  localparam int CLK  = 8;
  localparam int DT   = 1;
  localparam int BW   = 3;
  localparam int FR   = DIG * CLK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_in, blank;
  logic        load, lz_blank;
  logic [2:0]  bright;
  logic [6:0]  seg;
  logic        dt;
  logic [3:0]  en_seg;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  int          m_n;
  logic [15:0] m_stg_data, m_shd_data;
  logic [3:0]  m_stg_dp, m_shd_dp, m_stg_blk, m_shd_blk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sevenseg_scan_ctrl #(
    .DIGITS(DIG), .CLK_DIV(CLK), .DEAD(DT), .BRIGHT_W(BW),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n),
    .data(data), .dp_in(dp_in), .blank(blank),
    .load(load), .lz_blank(lz_blank), .bright(bright),
    .seg(seg), .dt(dt), .en_seg(en_seg),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, m_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_stg_data = '0; m_shd_data = '0;
    m_stg_dp = '0;   m_shd_dp = '0;
    m_stg_blk = '0;  m_shd_blk = '0;
  endtask

  task automatic chk_dark();
    chk("rst_en", 32'(en_seg), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dt", 32'(dt), 32'h1);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
  endtask

  task automatic tick();
    int cnt, idx, pwm, nib;
    logic lit, sup, blk;
    logic [3:0] en_e;
    logic [6:0] seg_e;
    logic dt_e, ft_e;
    logic [1:0] idx_e;
    @(posedge clk);
    cnt = m_n % CLK;
    idx = (m_n / CLK) % DIG;
    pwm = m_n % (1 << BW);
    blk = m_shd_blk[idx];
    nib = int'((m_shd_data >> (4 * idx)) & 16'hF);
    sup = lz_blank && idx >= 1 && ((m_shd_data >> (4 * idx)) == 16'h0);
    lit = cnt >= DT && pwm <= int'(bright) && !blk;
    en_e  = lit ? ~(4'b0001 << idx) : 4'hF;
    seg_e = (blk || sup) ? 7'h7F : ~hex_tab[nib];
    dt_e  = (m_shd_dp[idx] && !blk) ? 1'b0 : 1'b1;
    if (m_n % FR == FR - 1) begin
      m_shd_data = load ? data  : m_stg_data;
      m_shd_dp   = load ? dp_in : m_stg_dp;
      m_shd_blk  = load ? blank : m_stg_blk;
    end
    if (load) begin
      m_stg_data = data; m_stg_dp = dp_in; m_stg_blk = blank;
    end
    m_n++;
    idx_e = 2'((m_n / CLK) % DIG);
    ft_e  = (m_n % FR) == 0;
    #1;
    chk("en", 32'(en_seg), 32'(en_e));
    chk("idx", 32'(digit_idx), 32'(idx_e));
    chk("ft", 32'(frame_tick), 32'(ft_e));
    if (lit || blk) begin
      chk("seg", 32'(seg), 32'(seg_e));
      chk("dt", 32'(dt), 32'(dt_e));
    end
    @(negedge clk);
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic ld(input logic [15:0] d, input logic [3:0] p,
                    input logic [3:0] b);
    data = d; dp_in = p; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    data = '0; dp_in = '0; blank = '0;
    load = 1'b0; lz_blank = 1'b0; bright = 3'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_dark();
    @(negedge clk);
    rst_n = 1'b1;

    ld(16'h5A3C, 4'b0011, 4'b0000);
    run(19);
    #2 rst_n = 1'b0;
    #1 chk_dark();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    ld(16'h12AF, 4'b0000, 4'b0000);
    run(80);

    run(14);
    ld(16'h1111, 4'b0000, 4'b0000);
    run(40);
    while (m_n % FR != FR - 1) tick();
    ld(16'h2222, 4'b1000, 4'b0000);
    run(FR);

    lz_blank = 1'b1;
    ld(16'h0070, 4'b0000, 4'b0000);
    run(2 * FR);
    ld(16'h0000, 4'b0000, 4'b0000);
    run(2 * FR);
    ld(16'h0300, 4'b1000, 4'b0000);
    run(2 * FR);
    lz_blank = 1'b0;

    bright = 3'd1;
    ld(16'h8888, 4'b0000, 4'b0000);
    run(2 * FR);
    bright = 3'd0;
    run(FR);
    bright = 3'd7;

    ld(16'h4321, 4'b0101, 4'b0100);
    run(2 * FR);

    for (int i = 0; i < 40; i++) begin
      data = 16'($urandom); dp_in = 4'($urandom); blank = 4'($urandom);
      load = 1'b1;
      tick();
    end
    load = 1'b0;
    run(FR);

    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 19) == 0);
      data = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 49) == 0) bright = 3'($urandom);
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
